// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Helpers work on a 16-bit space; callers cast to their own widths.
package arb_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    // Increment an index, wrapping at n.
    function automatic logic [3:0] next_idx(input logic [3:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: first set req bit at or above ptr, wrapping to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] sel
);

    always_comb begin
        logic [3:0] idx;
        valid = 1'b0;
        sel   = '0;
        idx   = 4'(ptr);
        for (int i = 0; i < N; i++) begin
            if (!valid && req[IDW'(idx)]) begin
                valid = 1'b1;
                sel   = IDW'(idx);
            end
            idx = next_idx(idx, N);
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter granting one requester at a time until done, request
// withdrawal or a hold limit; one idle cycle is always inserted between owners.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           timeout
);

    localparam int CW = $clog2(MAX_HOLD);

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n, owner_n, pick_sel;
    logic [CW-1:0]  cnt, cnt_n;
    logic           timeout_n, pick_valid;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        owner_n   = owner;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = HOLD;
                    owner_n = pick_sel;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                // A voluntary release wins over a coincident hold-limit hit.
                if (done[owner] || !req[owner]) begin
                    state_n = IDLE;
                    ptr_n   = IDW'(next_idx(4'(owner), N));
                end else if (cnt == CW'(MAX_HOLD - 1)) begin
                    state_n   = IDLE;
                    ptr_n     = IDW'(next_idx(4'(owner), N));
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            owner   <= owner_n;
            grant   <= (state_n == HOLD) ? N'(onehot(4'(owner_n))) : '0;
            busy    <= (state_n == HOLD);
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=4, MAX_HOLD=8) with an expectation queue.
module tb_rr_hold_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, done, grant;
    logic       busy, timeout;
    logic [1:0] owner;

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic       timeout;
        logic [1:0] owner;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the post-edge expectation, then check it.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] dn, input logic [3:0] eg,
                        input logic et, input logic [1:0] eo);
        exp_t e;
        reset = r;
        req   = rq;
        done  = dn;
        sbq.push_back('{grant: eg, busy: (eg != 4'b0), timeout: et, owner: eo});
        @(posedge clk);
        #1;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL %s queue: got empty expected entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            assert (grant === e.grant) else begin
                errors++;
                $error("FAIL %s grant: got %b expected %b", tag, grant, e.grant);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy: got %b expected %b", tag, busy, e.busy);
            end
            checks++;
            assert (timeout === e.timeout) else begin
                errors++;
                $error("FAIL %s timeout: got %b expected %b", tag, timeout, e.timeout);
            end
            checks++;
            assert (owner === e.owner) else begin
                errors++;
                $error("FAIL %s owner: got %0d expected %0d", tag, owner, e.owner);
            end
        end
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] oh_next;
        reset = 1'b1;
        req   = 4'b0;
        done  = 4'b0;

        // Reset held with all requesting
        step("rst0", 1, 4'b1111, 4'b0, 4'b0000, 0, 2'd0);
        step("rst1", 1, 4'b1111, 4'b0, 4'b0000, 0, 2'd0);
        step("rst_rel", 0, 4'b1111, 4'b0, 4'b0001, 0, 2'd0);

        // Rotation: each grant lasts 2 cycles, done on the second
        for (int g = 0; g < 5; g++) begin
            oh      = 4'b0001 << (g % 4);
            oh_next = 4'b0001 << ((g + 1) % 4);
            step("rot_hold", 0, 4'b1111, 4'b0, oh, 0, 2'(g % 4));
            step("rot_rel", 0, 4'b1111, oh, 4'b0000, 0, 2'(g % 4));
            if (g < 4)
                step("rot_pick", 0, 4'b1111, 4'b0, oh_next, 0, 2'((g + 1) % 4));
        end

        // Done release and gap, requester 2 only (ptr=1)
        step("dn_pick", 0, 4'b0100, 4'b0, 4'b0100, 0, 2'd2);
        step("dn_c2", 0, 4'b0100, 4'b0, 4'b0100, 0, 2'd2);
        step("dn_c3", 0, 4'b0100, 4'b0, 4'b0100, 0, 2'd2);
        step("dn_rel", 0, 4'b0100, 4'b0100, 4'b0000, 0, 2'd2);
        step("dn_repick", 0, 4'b0100, 4'b0, 4'b0100, 0, 2'd2);
        step("dn_drop", 0, 4'b0000, 4'b0, 4'b0000, 0, 2'd2);
        // ptr=3 now, so 3 wins over 2
        step("ptr3_pick", 0, 4'b1100, 4'b0, 4'b1000, 0, 2'd3);
        step("ptr3_drop", 0, 4'b0000, 4'b0, 4'b0000, 0, 2'd3);

        // Timeout: exactly 8 grant cycles then a one-cycle pulse
        step("to_pick", 0, 4'b0010, 4'b0, 4'b0010, 0, 2'd1);
        for (int c = 2; c <= 8; c++)
            step("to_hold", 0, 4'b0010, 4'b0, 4'b0010, 0, 2'd1);
        step("to_fire", 0, 4'b0010, 4'b0, 4'b0000, 1, 2'd1);
        step("to_regrant", 0, 4'b0010, 4'b0, 4'b0010, 0, 2'd1);
        for (int c = 2; c <= 8; c++)
            step("to2_hold", 0, 4'b0010, 4'b0, 4'b0010, 0, 2'd1);
        step("to_done_tie", 0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1);
        step("to_idle", 0, 4'b0000, 4'b0, 4'b0000, 0, 2'd1);

        // Bring ptr back to 0 via requester 3
        step("p0_pick", 0, 4'b1000, 4'b0, 4'b1000, 0, 2'd3);
        step("p0_drop", 0, 4'b0000, 4'b0, 4'b0000, 0, 2'd3);

        // Non-owner done/req are ignored
        step("no_pick", 0, 4'b1101, 4'b0, 4'b0001, 0, 2'd0);
        step("no_other", 0, 4'b1001, 4'b1000, 4'b0001, 0, 2'd0);
        step("no_steady", 0, 4'b1001, 4'b0, 4'b0001, 0, 2'd0);
        step("no_withdraw", 0, 4'b1000, 4'b0, 4'b0000, 0, 2'd0);
        step("no_pick3", 0, 4'b1000, 4'b0, 4'b1000, 0, 2'd3);

        // Reset mid-HOLD with cnt=5
        for (int c = 1; c <= 5; c++)
            step("mh_hold", 0, 4'b1000, 4'b0, 4'b1000, 0, 2'd3);
        step("mh_reset", 1, 4'b1001, 4'b0, 4'b0000, 0, 2'd0);
        step("mh_pick", 0, 4'b1001, 4'b0, 4'b0001, 0, 2'd0);
        step("mh_hold2", 0, 4'b1001, 4'b0, 4'b0001, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
